// File: rtl/obi_cmd_manager_if.sv
// OBI bus between the command manager (master) and a subordinate (slave):
// the A channel with its req/gnt handshake, and the R channel with rvalid/rready.
interface obi_cmd_manager_if #(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32,
   parameter int IdWidth   = 1
);
   logic                   req;
   logic                   gnt;
   logic [AddrWidth-1:0]   addr;
   logic                   we;
   logic [DataWidth/8-1:0] be;
   logic [DataWidth-1:0]   wdata;
   logic [IdWidth-1:0]     aid;
   logic                   rvalid;
   logic                   rready;
   logic [DataWidth-1:0]   rdata;
   logic                   err;
   logic [IdWidth-1:0]     rid;

   modport master (
      output req, addr, we, be, wdata, aid, rready,
      input  gnt, rvalid, rdata, err, rid
   );

   modport slave (
      input  req, addr, we, be, wdata, aid, rready,
      output gnt, rvalid, rdata, err, rid
   );
endinterface

// File: rtl/obi_cmd_manager.sv
// OBI manager: valid/ready commands in, in-order OBI transactions out, buffered responses back.
// Optional OBI_MGR_ID_CHECK_EN: check r.rid against the expected completion ID, flag mismatches.
module obi_cmd_manager #(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32,
   parameter int IdWidth   = 1,
   parameter int MaxTrans  = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   cmd_valid_i,
   output logic                   cmd_ready_o,
   input  logic                   cmd_we_i,
   input  logic [AddrWidth-1:0]   cmd_addr_i,
   input  logic [DataWidth-1:0]   cmd_wdata_i,
   input  logic [DataWidth/8-1:0] cmd_be_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [DataWidth-1:0]   rsp_rdata_o,
   output logic                   rsp_err_o,
   obi_cmd_manager_if.master      obi,
   output logic                   busy_o,
   output logic                   id_err_o
);
   localparam int CntW = $clog2(MaxTrans + 1) + 1;
   localparam int PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;

   typedef enum logic {IDLE, REQ} state_t;

   state_t                   state, state_next;
   logic                     a_we;
   logic [AddrWidth-1:0]     a_addr;
   logic [DataWidth-1:0]     a_wdata;
   logic [DataWidth/8-1:0]   a_be;
   logic [IdWidth-1:0]       issue_id, cmpl_id;
   logic [CntW-1:0]          outstanding, fifo_cnt, inflight;
   logic [PtrW-1:0]          wr_ptr, rd_ptr;
   logic [DataWidth-1:0]     fifo_rdata [MaxTrans];
   logic                     fifo_err   [MaxTrans];
   logic                     cmd_fire, gnt_fire, rvalid_fire, pop;
   logic                     id_mismatch, resp_err;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(MaxTrans - 1)) ? '0 : p + 1'b1;
   endfunction

   // Credit counts the pending request, granted-not-responded and buffered responses,
   // so a returned response always finds room and rready can stay high.
   assign inflight    = CntW'(state == REQ) + outstanding + fifo_cnt;
   assign cmd_ready_o = (state == IDLE) && (inflight < CntW'(MaxTrans));
   assign cmd_fire    = cmd_valid_i && cmd_ready_o;
   assign gnt_fire    = (state == REQ) && obi.gnt;
   assign rvalid_fire = obi.rvalid && (outstanding != '0);
   assign rsp_valid_o = (fifo_cnt != '0);
   assign pop         = rsp_valid_o && rsp_ready_i;
   assign busy_o      = (inflight != '0);

`ifdef OBI_MGR_ID_CHECK_EN
   logic id_err_q;

   assign id_mismatch = (obi.rid != cmpl_id);
   assign id_err_o    = id_err_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         id_err_q <= 1'b0;
      end else if (rvalid_fire && id_mismatch) begin
         id_err_q <= 1'b1;
      end
   end
`else
   logic unused_rid;

   assign unused_rid  = ^{obi.rid, cmpl_id};
   assign id_mismatch = 1'b0;
   assign id_err_o    = 1'b0;
`endif

   assign resp_err = obi.err | id_mismatch;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Once req is raised it stays up until granted; a request is never withdrawn.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (cmd_fire) state_next = REQ;
         REQ:     if (obi.gnt)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_we    <= 1'b0;
         a_addr  <= '0;
         a_wdata <= '0;
         a_be    <= '0;
      end else if (cmd_fire) begin
         a_we    <= cmd_we_i;
         a_addr  <= cmd_addr_i;
         a_wdata <= cmd_wdata_i;
         a_be    <= cmd_be_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         issue_id    <= '0;
         cmpl_id     <= '0;
         outstanding <= '0;
      end else begin
         if (gnt_fire)    issue_id <= issue_id + 1'b1;
         if (rvalid_fire) cmpl_id  <= cmpl_id + 1'b1;
         outstanding <= outstanding + CntW'(gnt_fire) - CntW'(rvalid_fire);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (rvalid_fire) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)         rd_ptr <= ptr_inc(rd_ptr);
         fifo_cnt <= fifo_cnt + CntW'(rvalid_fire) - CntW'(pop);
      end
   end

   // Storage needs no reset: the outputs are gated by rsp_valid_o.
   always_ff @(posedge clk_i) begin
      if (rvalid_fire) begin
         fifo_rdata[wr_ptr] <= obi.rdata;
         fifo_err[wr_ptr]   <= resp_err;
      end
   end

   assign rsp_rdata_o = rsp_valid_o ? fifo_rdata[rd_ptr] : '0;
   assign rsp_err_o   = rsp_valid_o & fifo_err[rd_ptr];

   assign obi.req    = (state == REQ);
   assign obi.we     = a_we;
   assign obi.addr   = a_addr;
   assign obi.wdata  = a_wdata;
   assign obi.be     = a_be;
   assign obi.aid    = issue_id;
   assign obi.rready = 1'b1;

   rvalid_without_outstanding : assert property (
      @(posedge clk_i) disable iff (rst_i) !(obi.rvalid && (outstanding == '0))
   );
endmodule

// File: tb/tb_obi_cmd_manager.sv
// Bench for obi_cmd_manager: random command/grant/response traffic against a queue-based
// model of the manager and a register-file subordinate, plus directed scenarios.
module tb_obi_cmd_manager;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 1;
   localparam int MT = 2;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } cmd_t;

   typedef struct {
      logic [31:0] rdata;
      bit          err;
      bit          corrupt;
      int          id;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_be;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic        busy, id_err;

   obi_cmd_manager_if #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) obi ();

   obi_cmd_manager #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .MaxTrans(MT)) dut (
      .clk_i(clk), .rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
      .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_be_i(cmd_be),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
      .rsp_err_o(rsp_err), .obi(obi), .busy_o(busy), .id_err_o(id_err)
   );

   always #5 clk = ~clk;

   cmd_t        cmd_q [$];
   cmd_t        pend;
   bit          pend_valid = 1'b0;
   rsp_t        sub_q [$];
   rsp_t        exp_q [$];
   rsp_t        resp_log [$];
   int          aid_log [$];
   logic [31:0] mem [16];
   int          issue_cnt = 0;
   bit          id_err_exp = 1'b0;
   int          wr_grants = 0;
   int          checks = 0;
   int          failures = 0;
   int          cmd_pct = 100, gnt_pct = 100, rvalid_pct = 100, rready_pct = 100, corrupt_pct = 0;
   bit          rst_req = 1'b1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be);
      cmd_t c;
      c.we = we; c.addr = addr; c.wdata = wdata; c.be = be;
      cmd_q.push_back(c);
   endtask

   task automatic stepCycles(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic waitIdle(input string name, input int limit);
      int n = 0;
      while ((cmd_q.size() != 0 || pend_valid || sub_q.size() != 0 || exp_q.size() != 0) && n < limit) begin
         stepCycles(1);
         n++;
      end
      checkOutput(name, (n < limit), 1);
   endtask

   task automatic doReset();
      rst_req = 1'b1;
      stepCycles(3);
      checkOutput("rst_cmd_ready", cmd_ready, 1);
      checkOutput("rst_rready", obi.rready, 1);
      checkOutput("rst_req", obi.req, 0);
      checkOutput("rst_rsp_valid", rsp_valid, 0);
      checkOutput("rst_rsp_rdata", rsp_rdata, 0);
      checkOutput("rst_rsp_err", rsp_err, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_id_err", id_err, 0);
      checkOutput("rst_aid", obi.aid, 0);
      rst_req = 1'b0;
   endtask

   // Per cycle: compare DUT outputs with the model, drive the next inputs, then advance
   // the model to what the coming clock edge must produce.
   initial begin : cycle_proc
      int   inflight, idx;
      bit   exp_ready, do_rst, cv, g, rv, rr;
      rsp_t r;
      rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
      rsp_ready = 1'b0; obi.gnt = 1'b0; obi.rvalid = 1'b0; obi.rdata = '0; obi.err = 1'b0; obi.rid = '0;
      forever begin
         @(negedge clk);
         inflight  = (pend_valid ? 1 : 0) + sub_q.size() + exp_q.size();
         exp_ready = !pend_valid && (inflight < MT);
         checkOutput("cmd_ready", cmd_ready, exp_ready);
         checkOutput("req", obi.req, pend_valid);
         if (pend_valid) begin
            checkOutput("a_we", obi.we, pend.we);
            checkOutput("a_addr", obi.addr, pend.addr);
            checkOutput("a_wdata", obi.wdata, pend.wdata);
            checkOutput("a_be", obi.be, pend.be);
            checkOutput("a_aid", obi.aid, issue_cnt % (1 << IW));
         end
         checkOutput("rready", obi.rready, 1);
         checkOutput("rsp_valid", rsp_valid, exp_q.size() != 0);
         if (exp_q.size() != 0) begin
            checkOutput("rsp_rdata", rsp_rdata, exp_q[0].rdata);
            checkOutput("rsp_err", rsp_err, exp_q[0].err);
         end
         checkOutput("busy", busy, inflight != 0);
         checkOutput("id_err", id_err, id_err_exp);

         do_rst = rst_req;
         cv = !do_rst && cmd_q.size() != 0 && ($urandom_range(99) < cmd_pct);
         g  = !do_rst && ($urandom_range(99) < gnt_pct);
         rv = !do_rst && sub_q.size() != 0 && ($urandom_range(99) < rvalid_pct);
         rr = ($urandom_range(99) < rready_pct);
         rst = do_rst;
         cmd_valid = cv;
         if (cv) begin
            cmd_we = cmd_q[0].we; cmd_addr = cmd_q[0].addr; cmd_wdata = cmd_q[0].wdata; cmd_be = cmd_q[0].be;
         end else begin
            cmd_we = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom; cmd_be = 4'($urandom);
         end
         obi.gnt = g;
         obi.rvalid = rv;
         if (rv) begin
            obi.rdata = sub_q[0].rdata;
            obi.err   = sub_q[0].err;
            obi.rid   = IW'(sub_q[0].id) ^ IW'(sub_q[0].corrupt);
         end else begin
            obi.rdata = $urandom; obi.err = 1'($urandom); obi.rid = IW'($urandom);
         end
         rsp_ready = rr;
         if (!do_rst && g && obi.req === 1'b1) begin
            aid_log.push_back(int'(obi.aid));
            if (obi.we === 1'b1) wr_grants++;
         end
         if (!do_rst && rr && rsp_valid === 1'b1) begin
            r.rdata = rsp_rdata; r.err = rsp_err; r.corrupt = 1'b0; r.id = 0;
            resp_log.push_back(r);
         end

         if (do_rst) begin
            pend_valid = 1'b0;
            sub_q.delete();
            exp_q.delete();
            issue_cnt = 0;
            id_err_exp = 1'b0;
         end else begin
            if (rr && exp_q.size() != 0) void'(exp_q.pop_front());
            if (rv) begin
               r = sub_q.pop_front();
`ifdef OBI_MGR_ID_CHECK_EN
               if (r.corrupt) begin
                  r.err = 1'b1;
                  id_err_exp = 1'b1;
               end
`endif
               exp_q.push_back(r);
            end
            if (g && pend_valid) begin
               idx = int'(pend.addr[5:2]);
               r.id = issue_cnt;
               r.corrupt = ($urandom_range(99) < corrupt_pct);
               r.err = (pend.addr == 32'h3C);
               r.rdata = pend.we ? 32'h0 : mem[idx];
               if (pend.we && !r.err) begin
                  for (int b = 0; b < 4; b++)
                     if (pend.be[b]) mem[idx][8*b +: 8] = pend.wdata[8*b +: 8];
               end
               sub_q.push_back(r);
               issue_cnt++;
               pend_valid = 1'b0;
            end
            if (cv && exp_ready) begin
               pend = cmd_q.pop_front();
               pend_valid = 1'b1;
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int base, g0;
      for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
      doReset();

      // Single write, granted immediately
      base = resp_log.size(); g0 = wr_grants;
      applyStimulus(1'b1, 32'h04, 32'h0000_00FF, 4'hF);
      waitIdle("write_done", 200);
      checkOutput("write_resp_count", resp_log.size() - base, 1);
      checkOutput("write_rdata", resp_log[base].rdata, 32'h0);
      checkOutput("write_err", resp_log[base].err, 0);
      checkOutput("write_grant_once", wr_grants - g0, 1);

      // Read with grant withheld for several cycles
      applyStimulus(1'b1, 32'h08, 32'h0000_A5A5, 4'hF);
      waitIdle("write2_done", 200);
      gnt_pct = 0;
      base = resp_log.size();
      applyStimulus(1'b0, 32'h08, 32'h0, 4'hF);
      stepCycles(5);
      checkOutput("stall_req", obi.req, 1);
      checkOutput("stall_cmd_ready", cmd_ready, 0);
      checkOutput("stall_addr", obi.addr, 32'h08);
      gnt_pct = 100;
      waitIdle("stall_read_done", 200);
      checkOutput("stall_resp_count", resp_log.size() - base, 1);
      checkOutput("stall_rdata", resp_log[base].rdata, 32'h0000_A5A5);

      // Back-pressure on the response stream limits issue to MaxTrans
      rready_pct = 0;
      g0 = aid_log.size(); base = resp_log.size();
      applyStimulus(1'b0, 32'h10, 32'h0, 4'hF);
      applyStimulus(1'b0, 32'h14, 32'h0, 4'hF);
      applyStimulus(1'b0, 32'h18, 32'h0, 4'hF);
      stepCycles(10);
      checkOutput("bp_issued", aid_log.size() - g0, 2);
      checkOutput("bp_cmd_ready", cmd_ready, 0);
      checkOutput("bp_rsp_valid", rsp_valid, 1);
      checkOutput("bp_busy", busy, 1);
      rready_pct = 100;
      waitIdle("bp_done", 200);
      checkOutput("bp_resp_count", resp_log.size() - base, 3);
      checkOutput("bp_rdata0", resp_log[base].rdata, 32'h1000_0004);
      checkOutput("bp_rdata1", resp_log[base + 1].rdata, 32'h1000_0005);
      checkOutput("bp_rdata2", resp_log[base + 2].rdata, 32'h1000_0006);

      // Subordinate error followed by a clean transaction
      base = resp_log.size();
      applyStimulus(1'b0, 32'h3C, 32'h0, 4'hF);
      applyStimulus(1'b0, 32'h0C, 32'h0, 4'hF);
      waitIdle("err_done", 200);
      checkOutput("err_resp_count", resp_log.size() - base, 2);
      checkOutput("err_first", resp_log[base].err, 1);
      checkOutput("err_second", resp_log[base + 1].err, 0);
      checkOutput("err_second_rdata", resp_log[base + 1].rdata, 32'h1000_0003);

      // ID wrap with back-to-back reads from a fresh reset
      doReset();
      g0 = aid_log.size(); base = resp_log.size();
      applyStimulus(1'b0, 32'h00, 32'h0, 4'hF);
      applyStimulus(1'b0, 32'h04, 32'h0, 4'hF);
      applyStimulus(1'b0, 32'h08, 32'h0, 4'hF);
      applyStimulus(1'b0, 32'h0C, 32'h0, 4'hF);
      waitIdle("wrap_done", 200);
      checkOutput("wrap_grants", aid_log.size() - g0, 4);
      checkOutput("wrap_aid0", aid_log[g0], 0);
      checkOutput("wrap_aid1", aid_log[g0 + 1], 1);
      checkOutput("wrap_aid2", aid_log[g0 + 2], 0);
      checkOutput("wrap_aid3", aid_log[g0 + 3], 1);
      checkOutput("wrap_resp_count", resp_log.size() - base, 4);
      checkOutput("wrap_rdata0", resp_log[base].rdata, 32'h1000_0000);
      checkOutput("wrap_rdata1", resp_log[base + 1].rdata, 32'h0000_00FF);
      checkOutput("wrap_rdata2", resp_log[base + 2].rdata, 32'h0000_A5A5);
      checkOutput("wrap_rdata3", resp_log[base + 3].rdata, 32'h1000_0003);

`ifdef OBI_MGR_ID_CHECK_EN
      // Wrong rid flags the response and sets the sticky flag
      corrupt_pct = 100;
      base = resp_log.size();
      applyStimulus(1'b0, 32'h10, 32'h0, 4'hF);
      waitIdle("idchk_done", 200);
      corrupt_pct = 0;
      checkOutput("idchk_err", resp_log[base].err, 1);
      checkOutput("idchk_flag", id_err, 1);
      applyStimulus(1'b0, 32'h14, 32'h0, 4'hF);
      waitIdle("idchk2_done", 200);
      checkOutput("idchk2_err", resp_log[base + 1].err, 0);
      checkOutput("idchk_sticky", id_err, 1);
      doReset();
`endif

      // Randomized traffic with varying handshake rates
      for (int i = 0; i < 300; i++)
         applyStimulus(1'($urandom), {26'h0, 4'($urandom_range(15)), 2'b00}, $urandom, 4'($urandom));
      corrupt_pct = 25;
      for (int k = 0; k < 60; k++) begin
         cmd_pct    = $urandom_range(30, 100);
         gnt_pct    = $urandom_range(20, 100);
         rvalid_pct = $urandom_range(20, 100);
         rready_pct = $urandom_range(10, 100);
         stepCycles(25);
      end
      cmd_pct = 100; gnt_pct = 100; rvalid_pct = 100; rready_pct = 100;
      waitIdle("random_done", 3000);
      corrupt_pct = 0;

      // Reset with transactions in flight, then recover
      doReset();
      gnt_pct = 60; rvalid_pct = 50; rready_pct = 30;
      for (int i = 0; i < 10; i++)
         applyStimulus(1'b0, {26'h0, 4'($urandom_range(15)), 2'b00}, 32'h0, 4'hF);
      stepCycles(7);
      cmd_q.delete();
      doReset();
      gnt_pct = 100; rvalid_pct = 100; rready_pct = 100;
      base = resp_log.size();
      applyStimulus(1'b1, 32'h20, 32'h1234_5678, 4'h3);
      applyStimulus(1'b0, 32'h20, 32'h0, 4'hF);
      waitIdle("recover_done", 200);
      checkOutput("recover_resp_count", resp_log.size() - base, 2);
      checkOutput("recover_rdata_lo", resp_log[base + 1].rdata[15:0], 16'h5678);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
